// File: rtl/bus_rr.sv
// Round-robin block-transfer bus: N cache controllers share one memory port.
// The grant is held for a whole block, and each new transaction is broadcast as a snoop.
module bus_rr #(
  parameter int num_caches_p     = 2,
  parameter int block_width_p    = 8,
  parameter int dma_data_width_p = 2
) (
  input  logic                                                  clk_i,
  input  logic                                                  nreset_i,
  input  logic [num_caches_p-1:0]                               cb_valid_i,
  output logic [num_caches_p-1:0]                               cb_yumi_o,
  input  logic [num_caches_p-1:0][32*dma_data_width_p+32:0]     cb_pkt_i,
  output logic [num_caches_p-1:0]                               cb_valid_o,
  output logic [dma_data_width_p*32-1:0]                        cb_data_o,
  input  logic                                                  mem_ready_i,
  output logic                                                  mem_valid_o,
  output logic                                                  mem_we_o,
  output logic [31:0]                                           mem_addr_o,
  output logic [dma_data_width_p*32-1:0]                        mem_wdata_o,
  input  logic                                                  mem_valid_i,
  input  logic [dma_data_width_p*32-1:0]                        mem_data_i,
  output logic [num_caches_p-1:0]                               snoop_valid_o,
  output logic                                                  snoop_we_o,
  output logic [31:0]                                           snoop_addr_o,
  output logic [((num_caches_p > 1) ? $clog2(num_caches_p) : 1)-1:0] grant_id_o,
  output logic                                                  busy_o
);

  localparam int beats_lp      = block_width_p / dma_data_width_p;
  localparam int id_width_lp   = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
  localparam int beat_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int dw_lp         = dma_data_width_p * 32;
  localparam logic [beat_width_lp-1:0] last_beat_lp = beat_width_lp'(beats_lp - 1);
  localparam logic [id_width_lp-1:0]   last_id_lp   = id_width_lp'(num_caches_p - 1);

  typedef struct packed {
    logic             we;
    logic [31:0]      addr;
    logic [dw_lp-1:0] wdata;
  } cache_bus_pkt_t;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

  state_e                   state_r, state_n;
  logic [id_width_lp-1:0]   owner_r, owner_n;
  logic [id_width_lp-1:0]   last_r, last_n;
  logic [beat_width_lp-1:0] beat_r, beat_n;

  logic [id_width_lp-1:0]   g;
  logic [id_width_lp-1:0]   scan_idx;
  logic                     found;
  logic                     issue;
  logic                     yumi_own;
  cache_bus_pkt_t           pkt_g;
  cache_bus_pkt_t           pkt_o;

  // Rotating priority: start scanning just past the last grantee.
  always_comb begin
    g        = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int i = 1; i <= num_caches_p; i++) begin
      scan_idx = id_width_lp'((int'(last_r) + i) % num_caches_p);
      if (!found && cb_valid_i[scan_idx]) begin
        found = 1'b1;
        g     = scan_idx;
      end
    end
  end

  assign pkt_g     = cb_pkt_i[g];
  assign pkt_o     = cb_pkt_i[owner_r];
  assign issue     = (state_r == IDLE) && (|cb_valid_i) && mem_ready_i;
  assign yumi_own  = cb_valid_i[owner_r] & mem_ready_i;
  assign cb_data_o = mem_data_i;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r <= IDLE;
      owner_r <= '0;
      last_r  <= last_id_lp;
      beat_r  <= '0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      last_r  <= last_n;
      beat_r  <= beat_n;
    end
  end

  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    last_n  = last_r;
    beat_n  = beat_r;
    case (state_r)
      IDLE: begin
        if (issue) begin
          owner_n = g;
          last_n  = g;
          beat_n  = '0;
          if (!pkt_g.we) begin
            state_n = READ;
          end else if (beats_lp > 1) begin
            state_n = WRITE;
            beat_n  = beat_width_lp'(1);
          end
        end
      end
      WRITE: begin
        if (yumi_own) begin
          if (beat_r == last_beat_lp) begin
            state_n = IDLE;
            beat_n  = '0;
          end else begin
            beat_n = beat_r + 1'b1;
          end
        end
      end
      READ: begin
        if (mem_valid_i) begin
          if (beat_r == last_beat_lp) begin
            state_n = IDLE;
            beat_n  = '0;
          end else begin
            beat_n = beat_r + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Everything except read data is forced low while reset is asserted.
  always_comb begin
    cb_yumi_o     = '0;
    cb_valid_o    = '0;
    mem_valid_o   = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    snoop_valid_o = '0;
    snoop_we_o    = 1'b0;
    snoop_addr_o  = '0;
    grant_id_o    = '0;
    busy_o        = 1'b0;
    if (nreset_i) begin
      busy_o     = (state_r != IDLE);
      grant_id_o = owner_r;
      case (state_r)
        IDLE: begin
          if (issue) begin
            mem_valid_o  = 1'b1;
            mem_we_o     = pkt_g.we;
            mem_addr_o   = pkt_g.addr;
            mem_wdata_o  = pkt_g.wdata;
            cb_yumi_o[g] = 1'b1;
            snoop_we_o   = pkt_g.we;
            snoop_addr_o = pkt_g.addr;
            for (int k = 0; k < num_caches_p; k++) begin
              snoop_valid_o[k] = (id_width_lp'(k) != g);
            end
          end
        end
        WRITE: begin
          mem_valid_o        = cb_valid_i[owner_r];
          mem_we_o           = pkt_o.we;
          mem_addr_o         = pkt_o.addr;
          mem_wdata_o        = pkt_o.wdata;
          cb_yumi_o[owner_r] = yumi_own;
        end
        READ: begin
          cb_valid_o[owner_r] = mem_valid_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr.sv
// Directed bench for bus_rr: a 4-cache / 4-beat bus driven from a vector table,
// plus a 3-cache / 1-beat bus exercising round-robin rotation.
module tb_bus_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4 caches, block 8, beat 2 words -> 4 beats
  logic [3:0]        d_valid = '0;
  logic [3:0]        d_yumi;
  logic [3:0][96:0]  d_pkt = '0;
  logic [3:0]        d_cbv;
  logic [63:0]       d_cbdata;
  logic              d_ready = 1'b0;
  logic              d_mvalid;
  logic              d_mwe;
  logic [31:0]       d_maddr;
  logic [63:0]       d_mwdata;
  logic              d_mvalid_in = 1'b0;
  logic [63:0]       d_mdata = '0;
  logic [3:0]        d_snoop;
  logic              d_swe;
  logic [31:0]       d_saddr;
  logic [1:0]        d_grant;
  logic              d_busy;

  bus_rr #(.num_caches_p(4), .block_width_p(8), .dma_data_width_p(2)) u_dut (
    .clk_i(clk), .nreset_i(rst_n),
    .cb_valid_i(d_valid), .cb_yumi_o(d_yumi), .cb_pkt_i(d_pkt),
    .cb_valid_o(d_cbv), .cb_data_o(d_cbdata),
    .mem_ready_i(d_ready), .mem_valid_o(d_mvalid), .mem_we_o(d_mwe),
    .mem_addr_o(d_maddr), .mem_wdata_o(d_mwdata),
    .mem_valid_i(d_mvalid_in), .mem_data_i(d_mdata),
    .snoop_valid_o(d_snoop), .snoop_we_o(d_swe), .snoop_addr_o(d_saddr),
    .grant_id_o(d_grant), .busy_o(d_busy)
  );

  // 3 caches, single-beat blocks
  logic [2:0]        r_valid = '0;
  logic [2:0]        r_yumi;
  logic [2:0][96:0]  r_pkt = '0;
  logic [2:0]        r_cbv;
  logic [63:0]       r_cbdata;
  logic              r_ready = 1'b0;
  logic              r_mvalid;
  logic              r_mwe;
  logic [31:0]       r_maddr;
  logic [63:0]       r_mwdata;
  logic [2:0]        r_snoop;
  logic              r_swe;
  logic [31:0]       r_saddr;
  logic [1:0]        r_grant;
  logic              r_busy;

  bus_rr #(.num_caches_p(3), .block_width_p(2), .dma_data_width_p(2)) u_rr (
    .clk_i(clk), .nreset_i(rst_n),
    .cb_valid_i(r_valid), .cb_yumi_o(r_yumi), .cb_pkt_i(r_pkt),
    .cb_valid_o(r_cbv), .cb_data_o(r_cbdata),
    .mem_ready_i(r_ready), .mem_valid_o(r_mvalid), .mem_we_o(r_mwe),
    .mem_addr_o(r_maddr), .mem_wdata_o(r_mwdata),
    .mem_valid_i(1'b0), .mem_data_i(64'h0),
    .snoop_valid_o(r_snoop), .snoop_we_o(r_swe), .snoop_addr_o(r_saddr),
    .grant_id_o(r_grant), .busy_o(r_busy)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [3:0]  valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wtag;
    logic        ready;
    logic        mvalid;
    logic [63:0] mdata;
    logic [3:0]  e_yumi;
    logic        e_mvalid;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [63:0] e_mwdata;
    logic [3:0]  e_cbv;
    logic [3:0]  e_snoop;
    logic        e_swe;
    logic [31:0] e_saddr;
    logic        e_busy;
    logic [1:0]  e_grant;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  vec_t tbl[$];

  function automatic vec_t mk(string n, logic rn, logic [3:0] vl, logic we, logic [31:0] ad,
                              logic [31:0] tg, logic rdy, logic mv, logic [63:0] md,
                              logic [3:0] ey, logic emv, logic emwe, logic [31:0] ema,
                              logic [63:0] emw, logic [3:0] ecbv, logic [3:0] esn,
                              logic eswe, logic [31:0] esa, logic eb, logic [1:0] eg);
    vec_t v;
    v.name = n; v.rst_n = rn; v.valid = vl; v.we = we; v.addr = ad; v.wtag = tg;
    v.ready = rdy; v.mvalid = mv; v.mdata = md;
    v.e_yumi = ey; v.e_mvalid = emv; v.e_mwe = emwe; v.e_maddr = ema; v.e_mwdata = emw;
    v.e_cbv = ecbv; v.e_snoop = esn; v.e_swe = eswe; v.e_saddr = esa;
    v.e_busy = eb; v.e_grant = eg;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic ok;
    @(negedge clk);
    rst_n       = v.rst_n;
    d_valid     = v.valid;
    d_ready     = v.ready;
    d_mvalid_in = v.mvalid;
    d_mdata     = v.mdata;
    for (int k = 0; k < 4; k++) d_pkt[k] = {v.we, v.addr, 32'(k), v.wtag};
    #2;
    ok = (d_yumi == v.e_yumi) && (d_mvalid == v.e_mvalid) && (d_cbv == v.e_cbv) &&
         (d_snoop == v.e_snoop) && (d_busy == v.e_busy) && (d_grant == v.e_grant) &&
         (d_cbdata == v.mdata);
    if (v.e_mvalid || !v.rst_n)
      ok = ok && (d_mwe == v.e_mwe) && (d_maddr == v.e_maddr) && (d_mwdata == v.e_mwdata);
    if ((v.e_snoop != 4'b0) || !v.rst_n)
      ok = ok && (d_swe == v.e_swe) && (d_saddr == v.e_saddr);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got yumi=%b mv=%b we=%b addr=%h wd=%h cbv=%b cbd=%h snp=%b swe=%b saddr=%h busy=%b gnt=%0d; want yumi=%b mv=%b we=%b addr=%h wd=%h cbv=%b cbd=%h snp=%b swe=%b saddr=%h busy=%b gnt=%0d",
               v.name, d_yumi, d_mvalid, d_mwe, d_maddr, d_mwdata, d_cbv, d_cbdata, d_snoop,
               d_swe, d_saddr, d_busy, d_grant, v.e_yumi, v.e_mvalid, v.e_mwe, v.e_maddr,
               v.e_mwdata, v.e_cbv, v.mdata, v.e_snoop, v.e_swe, v.e_saddr, v.e_busy, v.e_grant);
    end
  endtask

  initial begin
    logic [2:0] exp_y;
    logic [1:0] exp_g;
    logic [1:0] exp_owner;
    logic       ok;

    //             name               rn vl   we addr      tag     rdy mv mdata         yumi mv we maddr    mwdata                  cbv  snp  swe saddr    busy gnt
    tbl.push_back(mk("reset",          0, 4'hF, 1, 32'h010, 32'h0,  1, 0, 64'h5A,       4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("mem_not_ready",  1, 4'h3, 1, 32'h010, 32'h0,  0, 0, 64'h5B,       4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("rd_req_c0",      1, 4'h1, 0, 32'h040, 32'h0,  1, 0, 64'h0,        4'h1, 1, 0, 32'h040, 64'h0,                  4'h0, 4'hE, 0, 32'h040, 0, 0));
    tbl.push_back(mk("rd_beat0",       1, 4'h0, 0, 32'h040, 32'h0,  1, 1, 64'h1111,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h1, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("rd_gap0",        1, 4'h2, 1, 32'h040, 32'h0,  1, 0, 64'h9999,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("rd_beat1",       1, 4'h2, 1, 32'h040, 32'h0,  1, 1, 64'h2222,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h1, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("rd_gap1",        1, 4'h2, 1, 32'h040, 32'h0,  1, 0, 64'h8888,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("rd_beat2",       1, 4'h2, 1, 32'h040, 32'h0,  1, 1, 64'h3333,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h1, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("rd_beat3",       1, 4'h2, 1, 32'h040, 32'h0,  1, 1, 64'h4444,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h1, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("stray_rdata",    1, 4'h0, 1, 32'h040, 32'h0,  1, 1, 64'h7777,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("wr_beat0_c1",    1, 4'h3, 1, 32'h100, 32'hA0, 1, 0, 64'h0,        4'h2, 1, 1, 32'h100, 64'h00000001_000000A0,  4'h0, 4'hD, 1, 32'h100, 0, 0));
    tbl.push_back(mk("wr_stall_ready", 1, 4'h3, 1, 32'h100, 32'hA1, 0, 0, 64'h0,        4'h0, 1, 1, 32'h100, 64'h00000001_000000A1,  4'h0, 4'h0, 0, 32'h0,   1, 1));
    tbl.push_back(mk("wr_beat1",       1, 4'h3, 1, 32'h100, 32'hA1, 1, 0, 64'h0,        4'h2, 1, 1, 32'h100, 64'h00000001_000000A1,  4'h0, 4'h0, 0, 32'h0,   1, 1));
    tbl.push_back(mk("wr_stall_valid", 1, 4'h1, 1, 32'h100, 32'hA2, 1, 0, 64'h0,        4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   1, 1));
    tbl.push_back(mk("wr_beat2",       1, 4'h3, 1, 32'h100, 32'hA2, 1, 0, 64'h0,        4'h2, 1, 1, 32'h100, 64'h00000001_000000A2,  4'h0, 4'h0, 0, 32'h0,   1, 1));
    tbl.push_back(mk("wr_beat3",       1, 4'h3, 1, 32'h100, 32'hA3, 1, 0, 64'h0,        4'h2, 1, 1, 32'h100, 64'h00000001_000000A3,  4'h0, 4'h0, 0, 32'h0,   1, 1));
    tbl.push_back(mk("b2b_rd_c0",      1, 4'h3, 0, 32'h200, 32'h0,  1, 0, 64'h0,        4'h1, 1, 0, 32'h200, 64'h0,                  4'h0, 4'hE, 0, 32'h200, 0, 1));
    tbl.push_back(mk("rd2_beat0",      1, 4'h0, 0, 32'h200, 32'h0,  1, 1, 64'hAAAA,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h1, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("rd2_beat1",      1, 4'h0, 0, 32'h200, 32'h0,  1, 1, 64'hBBBB,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h1, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("reset_mid_read", 0, 4'h4, 1, 32'h300, 32'h0,  1, 1, 64'hCCCC,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("late_rdata",     1, 4'h0, 1, 32'h300, 32'h0,  1, 1, 64'hDDDD,     4'h0, 0, 0, 32'h0,   64'h0,                  4'h0, 4'h0, 0, 32'h0,   0, 0));
    tbl.push_back(mk("first_grant_c0", 1, 4'hF, 1, 32'h300, 32'h0,  1, 0, 64'h0,        4'h1, 1, 1, 32'h300, 64'h0,                  4'h0, 4'hE, 1, 32'h300, 0, 0));
    tbl.push_back(mk("wr_c0_beat1",    1, 4'h1, 1, 32'h300, 32'h0,  1, 0, 64'h0,        4'h1, 1, 1, 32'h300, 64'h0,                  4'h0, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("wr_c0_beat2",    1, 4'h1, 1, 32'h300, 32'h0,  1, 0, 64'h0,        4'h1, 1, 1, 32'h300, 64'h0,                  4'h0, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("wr_c0_beat3",    1, 4'h1, 1, 32'h300, 32'h0,  1, 0, 64'h0,        4'h1, 1, 1, 32'h300, 64'h0,                  4'h0, 4'h0, 0, 32'h0,   1, 0));
    tbl.push_back(mk("snoop_c2",       1, 4'h4, 1, 32'h080, 32'h0,  1, 0, 64'h0,        4'h4, 1, 1, 32'h080, 64'h00000002_00000000,  4'h0, 4'hB, 1, 32'h080, 0, 0));
    tbl.push_back(mk("snoop_pulse",    1, 4'h4, 1, 32'h080, 32'h0,  1, 0, 64'h0,        4'h4, 1, 1, 32'h080, 64'h00000002_00000000,  4'h0, 4'h0, 0, 32'h0,   1, 2));

    foreach (tbl[i]) apply(tbl[i]);

    // Round-robin rotation on the 3-cache single-beat bus: all requesting.
    @(negedge clk);
    d_valid = '0;
    r_valid = 3'b111;
    r_ready = 1'b1;
    for (int k = 0; k < 3; k++) r_pkt[k] = {1'b1, 32'h1000 + 32'(k), 64'h0};
    exp_owner = 2'd0;
    for (int c = 0; c < 4; c++) begin
      exp_g = 2'(c % 3);
      exp_y = 3'b001 << exp_g;
      if (c > 0) @(negedge clk);
      #2;
      ok = (r_yumi == exp_y) && ($countones(r_yumi) == 1) && (r_snoop == ~exp_y) &&
           r_mvalid && r_mwe && (r_maddr == 32'h1000 + 32'(exp_g)) && !r_busy &&
           (r_grant == exp_owner) && (r_cbv == 3'b000);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL rr_cycle%0d: got yumi=%b snp=%b mv=%b we=%b addr=%h busy=%b gnt=%0d cbv=%b; want yumi=%b snp=%b mv=1 we=1 addr=%h busy=0 gnt=%0d cbv=000",
                 c, r_yumi, r_snoop, r_mvalid, r_mwe, r_maddr, r_busy, r_grant, r_cbv,
                 exp_y, ~exp_y, 32'h1000 + 32'(exp_g), exp_owner);
      end
      exp_owner = exp_g;
    end

    @(negedge clk);
    r_valid = '0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
